// File: rtl/systolic_output_collector_if.sv
// Handshake bundle between the PE array bottom row, the output collector and writeback.
// Array side drives column sums; writeback side drives out_ready.
interface systolic_output_collector_if #(
    parameter int unsigned N     = 4,
    parameter int unsigned ACC_W = 32
);
    logic                 in_valid;
    logic                 tile_first;
    logic                 tile_last;
    logic [N*ACC_W-1:0]   col_psum;
    logic                 out_valid;
    logic                 out_ready;
    logic [N*ACC_W-1:0]   out_data;

    modport master (
        output in_valid, tile_first, tile_last, col_psum, out_ready,
        input  out_valid, out_data
    );

    modport slave (
        input  in_valid, tile_first, tile_last, col_psum, out_ready,
        output out_valid, out_data
    );
endinterface

// File: rtl/systolic_output_collector.sv
// Deskews the skewed bottom-row column sums of the PE array, accumulates them
// across K-tiles and queues finished rows in a show-ahead FIFO for writeback.
module systolic_output_collector #(
    parameter int unsigned N     = 4,
    parameter int unsigned ACC_W = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    systolic_output_collector_if.slave bus,
    output logic [$clog2(DEPTH):0]    fifo_count,
    output logic [N-1:0]              acc_ovf,
    output logic                      drop_err
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned DL    = N - 1;
    localparam int unsigned VEC_W = N * ACC_W;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } ctrl_t;

    // Sideband delay line: lines the token up with the last (undelayed) lane.
    ctrl_t ctrl_sr [DL];
    logic  al_valid;
    logic  al_first;
    logic  al_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DL); i++) ctrl_sr[i] <= '0;
        end else begin
            ctrl_sr[0] <= {bus.in_valid, bus.tile_first, bus.tile_last};
            for (int i = 1; i < int'(DL); i++) ctrl_sr[i] <= ctrl_sr[i-1];
        end
    end

    assign al_valid = ctrl_sr[DL-1].valid;
    assign al_first = ctrl_sr[DL-1].first;
    assign al_last  = ctrl_sr[DL-1].last;

    // Per-lane delay of N-1-j cycles undoes the west-to-east activation skew.
    logic [N-1:0][ACC_W-1:0] aligned;

    for (genvar j = 0; j < int'(N); j++) begin : g_lane
        localparam int unsigned D = N - 1 - j;
        if (D == 0) begin : g_nodly
            assign aligned[j] = bus.col_psum[j*ACC_W +: ACC_W];
        end else begin : g_dly
            logic [ACC_W-1:0] sr [D];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k < int'(D); k++) sr[k] <= '0;
                end else begin
                    sr[0] <= bus.col_psum[j*ACC_W +: ACC_W];
                    for (int k = 1; k < int'(D); k++) sr[k] <= sr[k-1];
                end
            end
            assign aligned[j] = sr[D-1];
        end
    end

    // K-tile accumulation; overflow only meaningful when actually adding.
    logic [N-1:0][ACC_W-1:0] acc;
    logic [N-1:0][ACC_W-1:0] sum;
    logic [N-1:0]            ovf_hit;

    always_comb begin
        sum     = '0;
        ovf_hit = '0;
        for (int j = 0; j < int'(N); j++) begin
            if (al_first) begin
                sum[j] = aligned[j];
            end else begin
                sum[j]     = acc[j] + aligned[j];
                ovf_hit[j] = (acc[j][ACC_W-1] == aligned[j][ACC_W-1]) &&
                             (sum[j][ACC_W-1] != aligned[j][ACC_W-1]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            acc_ovf <= '0;
        end else if (al_valid) begin
            acc     <= sum;
            acc_ovf <= acc_ovf | ovf_hit;
        end
    end

    // Output FIFO with a registered head so out_data holds when empty.
    logic [VEC_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic [VEC_W-1:0] push_data;
    logic [VEC_W-1:0] head_nxt;
    logic [VEC_W-1:0] out_data_q;
    logic             out_valid_q;
    logic             pop;
    logic             push_req;
    logic             push;
    logic             full;
    logic             drop;

    assign push_data     = sum;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

    always_comb begin
        pop       = out_valid_q && bus.out_ready;
        push_req  = al_valid && al_last;
        full      = (fifo_count == CNT_W'(DEPTH));
        push      = push_req && (!full || pop);
        drop      = push_req && full && !pop;
        rd_nxt    = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
        count_nxt = fifo_count;
        if (push && !pop) begin
            count_nxt = fifo_count + CNT_W'(1);
        end else if (pop && !push) begin
            count_nxt = fifo_count - CNT_W'(1);
        end
        // The entry written this edge becomes head only when it lands at the new read slot.
        head_nxt = out_data_q;
        if (count_nxt != '0) begin
            head_nxt = (push && (rd_nxt == wr_ptr)) ? push_data : mem[rd_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            fifo_count  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            drop_err    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            rd_ptr      <= rd_nxt;
            fifo_count  <= count_nxt;
            out_valid_q <= (count_nxt != '0);
            out_data_q  <= head_nxt;
            if (drop) drop_err <= 1'b1;
        end
    end
endmodule

// File: doc/systolic_output_collector.md
Name: systolic_output_collector

Overview:
- Sits directly south of the bottom row of the weight-stationary PE array and consumes the N column partial sums.
- The array emits column j's result j cycles after column 0's, because activations are skewed west→east. This block deskews the columns into one aligned vector.
- It accumulates the vector across K-tiles, when the reduction dimension exceeds the array height.
- Finished output rows are buffered in a FIFO with a valid/ready interface toward the writeback logic.

Parameters:
- N, 4, number of array columns (output lanes); N ≥ 2.
- ACC_W, 32, partial-sum and accumulator width per lane (signed two's complement).
- DEPTH, 8, output FIFO entries; power of two.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  column-0 result of a new row is on col_psum lane 0 this cycle.
- tile_first  input  1  sideband with in_valid: this row starts a new accumulation (overwrite accumulator).
- tile_last  input  1  sideband with in_valid: this row completes the accumulation (push result).
- col_psum  input  N*ACC_W  bottom-row partial_sum_out; lane j at bits [j*ACC_W +: ACC_W].
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer accepts head.
- out_data  output  N*ACC_W  FIFO head, same lane packing as col_psum.
- fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy.
- acc_ovf  output  N  sticky per-lane signed-overflow flag.
- drop_err  output  1  sticky: a result was discarded because the FIFO was full.

Behaviour:
Reset:
- rst is synchronous and active-high; clk is the clock.
- On reset, all delay lines, accumulators, FIFO pointers, acc_ovf and drop_err clear to 0.
- After reset: out_valid=0, out_data=0, fifo_count=0.
- Reset mid-operation discards in-flight tokens. Lane inputs arriving after reset for a token issued before reset are ignored.

Deskew:
- Lane j passes through a register delay line of length N-1-j. Lane N-1 is not delayed.
- in_valid, tile_first and tile_last pass through one delay line of length N-1.
- For a token with in_valid at cycle T, the aligned vector (all lanes from the same row) and aligned_valid are available at cycle T+N-1.
- Tokens may arrive every cycle; the delay lines are fully pipelined and have no stalls.

Accumulate:
- This step occurs on the edge ending cycle T+N-1 when aligned_valid=1.
- sum_j = tile_first ? aligned_j : acc_j + aligned_j, computed at ACC_W bits with wrap-around.
- acc_j <= sum_j.
- Signed overflow on the add (operand signs equal, result sign differs) sets acc_ovf[j]. The flag is not set when tile_first=1.
- A token without a preceding tile_first adds to whatever acc holds (0 after reset).
- tile_first=1 and tile_last=1 together is a single-tile pass-through.

FIFO:
- On the same edge, if tile_last=1, {sum_N-1..sum_0} is written to the FIFO. The push uses the new sum, not the old acc.
- The FIFO is show-ahead: out_data reflects the head whenever out_valid=1.
- Pop occurs when out_valid && out_ready.
- Latency from in_valid to out_valid is N cycles when the FIFO is empty (N=4: in at cycle 0, out at cycle 4).
- When empty, out_data holds its last value and out_valid=0.
- Full and push without pop: the result is dropped, drop_err is set, and FIFO contents are unchanged. The accumulator still updates.
- Full with simultaneous push and pop: both take effect and fifo_count is unchanged.
- Empty with push: out_valid is not asserted until the next cycle; there is no bypass.
- Pointers wrap modulo DEPTH.
- fifo_count updates on the same edge as the push or pop.
- The array cannot stall, so there is no backpressure upstream. Consumers must drain the FIFO at or above the issue rate, or drop_err will fire.

Test Plan:
1. Single-tile pass-through, N=4.
   - Stimulus: in_valid=1 with first=last=1 at cycle 0; lane0=10 at c0, lane1=20 at c1, lane2=-30 at c2, lane3=40 at c3; out_ready=1.
   - Response: out_valid=1 at cycle 4 only, with lanes {10,20,-30,40}; fifo_count returns to 0.
2. Three-tile accumulation.
   - Stimulus: three tokens 1 cycle apart with lane values 1, 2, 3 in every lane; first on token 0, last on token 2.
   - Response: exactly one output, all lanes = 6, out_valid at cycle 2+N.
3. Back-to-back single tiles.
   - Stimulus: 6 tokens on consecutive cycles with lane value = token index k; out_ready=1.
   - Response: 6 outputs on consecutive cycles, in order, lanes = k; no drop_err.
4. Backpressure and overflow of the FIFO.
   - Stimulus: out_ready=0; 9 single-tile tokens with values 1..9.
   - Response: fifo_count=8 and drop_err=1 after the 9th. Raising out_ready then yields values 1..8 with no 9.
   - Follow-up: a push and pop in the same cycle while full leaves fifo_count=8.
5. Accumulator overflow.
   - Stimulus: lane 2 gets 0x7FFFFFFF (first) then 1 (last).
   - Response: output lane 2 = 0x80000000; acc_ovf=4'b0100; other lane bits stay 0.
6. Reset mid-operation.
   - Stimulus: issue a token, assert rst at cycle 2 for 1 cycle, then send one new single-tile token.
   - Response: the old token never appears; only the new result is output. Flags and fifo_count are 0 right after reset.
